seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_dec_unit.sv | 11 +
 rtl/seg_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment order is {a,b,c,d,e,f,g}; all patterns are active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex values above 9 have no glyph and stay dark.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/seg_dec_unit.sv
// Nibble to active-low seven-segment pattern, purely combinational.
module seg_dec_unit
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with anti-ghost blanking and a
// tear-free one-deep load buffer. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_e                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_frame_done;

  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_full;

  logic                    w_load_acc;
  logic                    w_commit;
  logic                    w_show;
  logic                    w_lit;
  logic                    w_lz_blank;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
          ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
              r_state <= ST_SHOW;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_SHOW: begin
            if (r_cnt == DIV_LAST) begin
              r_state <= ST_BLANK;
              r_cnt   <= '0;
              if (r_idx == IDX_LAST) begin
                r_idx        <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_idx <= r_idx + IDX_ONE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // The swap happens while digit 0 is still blanked, so a frame never mixes
  // two words; in IDLE nothing is lit and the swap is immediate.
  assign w_load_acc = load_valid & ~r_pend_full;
  assign w_commit   = r_pend_full & ((r_state == ST_IDLE) | r_frame_done);

  // NOTE: the data registers are reset as well because the blank display
  // after reset must decode a known all-zero word, not power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_commit) begin
      r_disp_data <= r_pend_data;
      r_disp_dp   <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_load_acc) begin
      r_pend_data <= load_data;
      r_pend_dp   <= load_dp;
      r_pend_full <= 1'b1;
    end
  end

  assign w_nibble = r_disp_data[{r_idx, 2'b00} +: 4];

  seg_dec_unit u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] w_msd;

  // Highest non-zero digit; digit 0 is the floor so it is never blanked.
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_disp_data[4*k +: 4] != 4'd0) w_msd = IDX_W'(k);
    end
  end

  assign w_lz_blank = (r_idx > w_msd);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_show = (r_state == ST_SHOW);
  assign w_lit  = w_show & ~w_lz_blank;

  // NOTE: the all-ones default before the conditional keeps this block
  // purely combinational; without it an_o would infer a latch.
  always_comb begin
    an_o = '1;
    if (w_show) an_o[r_idx] = 1'b0;
  end

  assign seg_o      = w_lit ? w_seg : SEG_BLANK;
  assign dp_o       = w_lit ? ~r_disp_dp[r_idx] : 1'b1;
  assign load_ready = ~r_pend_full;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, DIV=4, 2 blank cycles):
// directed table, hand-written corner sequences, and a randomized run against a timeline model.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DV    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = BC + DV;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DIV          (DV),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit lz_blanked(input logic [15:0] w, input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int k = 1; k < ND; k++) if (w[4*k +: 4] != 4'd0) msd = k;
    return d > msd;
`else
    return (w == 16'hFFFF) && (d > ND);
`endif
  endfunction

  // Timeline model: m_t counts cycles since scanning (re)started.
  bit          m_run;
  int          m_t;
  bit          m_fd;
  bit          m_pend_full;
  logic [15:0] m_pend_data, m_disp_data;
  logic [3:0]  m_pend_dp, m_disp_dp;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_fd = 0; m_pend_full = 0;
    m_pend_data = '0; m_disp_data = '0; m_pend_dp = '0; m_disp_dp = '0;
  endtask

  task automatic model_expect(output logic [3:0] ean, output logic [6:0] eseg, output logic edp);
    int p, d;
    ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
    if (m_run) begin
      p = m_t % FRAME;
      d = p / SLOT;
      if ((p % SLOT) >= BC) begin
        ean = ~(4'b0001 << d);
        if (!lz_blanked(m_disp_data, d)) begin
          eseg = ref_seg(m_disp_data[4*d +: 4]);
          edp  = ~m_disp_dp[d];
        end
      end
    end
  endtask

  task automatic model_step(input logic en, input logic lv, input logic [15:0] ld, input logic [3:0] ldp);
    bit accept, commit, fend;
    accept = lv && !m_pend_full;
    commit = m_pend_full && (!m_run || m_fd);
    fend   = m_run && en && ((m_t % FRAME) == FRAME - 1);
    if (commit) begin
      m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_pend_full = 0;
    end else if (accept) begin
      m_pend_data = ld; m_pend_dp = ldp; m_pend_full = 1;
    end
    m_fd = fend;
    if (!en) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drop to IDLE, load a word there, then start scanning. Returns on the
  // negedge just before the scan start edge.
  task automatic load_in_idle(input logic [15:0] d, input logic [3:0] dp);
    enable = 1'b0; load_valid = 1'b0;
    repeat (2) @(negedge clk);
    load_valid = 1'b1; load_data = d; load_dp = dp;
    @(negedge clk);
    load_valid = 1'b0; enable = 1'b1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    int          digit;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
  } vec_t;

  localparam int NT = 8;
  vec_t tbl [NT];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd_cnt, fd_first, fd_prev, bad_gap, fd_i, acc_i;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic       r_en, r_lv;
    logic [15:0] r_ld;
    logic [3:0]  r_ldp;

    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0;

    // Reset state.
    #2;
    check("rst_an",    32'(an_o),       32'hF);
    check("rst_seg",   32'(seg_o),      32'h7F);
    check("rst_dp",    32'(dp_o),       32'h1);
    check("rst_ready", 32'(load_ready), 32'h1);
    check("rst_fd",    32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode/select table.
    tbl[0] = '{16'h1234, 4'b0000, 0, 4'b1110, 7'b1001100, 1'b1};
    tbl[1] = '{16'h1234, 4'b0000, 3, 4'b0111, 7'b1001111, 1'b1};
    tbl[2] = '{16'hA000, 4'b0001, 3, 4'b0111, 7'b1111111, 1'b1};
    tbl[3] = '{16'hA000, 4'b0001, 0, 4'b1110, 7'b0000001, 1'b0};
    tbl[4] = '{16'h0050, 4'b0000, 1, 4'b1101, 7'b0100100, 1'b1};
    tbl[7] = '{16'h9876, 4'b0100, 2, 4'b1011, 7'b0000000, 1'b0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    tbl[5] = '{16'h0050, 4'b1000, 3, 4'b0111, 7'b1111111, 1'b1};
    tbl[6] = '{16'h0050, 4'b0000, 2, 4'b1011, 7'b1111111, 1'b1};
`else
    tbl[5] = '{16'h0050, 4'b1000, 3, 4'b0111, 7'b0000001, 1'b0};
    tbl[6] = '{16'h0050, 4'b0000, 2, 4'b1011, 7'b0000001, 1'b1};
`endif
    for (int i = 0; i < NT; i++) begin
      load_in_idle(tbl[i].data, tbl[i].dp);
      repeat (SLOT * tbl[i].digit + BC + 2) @(negedge clk);
      check($sformatf("tbl%0d_an", i),  32'(an_o),  32'(tbl[i].e_an));
      check($sformatf("tbl%0d_seg", i), 32'(seg_o), 32'(tbl[i].e_seg));
      check($sformatf("tbl%0d_dp", i),  32'(dp_o),  32'(tbl[i].e_dp));
    end

    // Frame timing: blanking, first digit and one frame_done per FRAME cycles.
    do_reset();
    load_in_idle(16'h1234, 4'b0000);
    fd_cnt = 0; fd_first = -1; fd_prev = -1; bad_gap = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n - 1 == 1) check("blank_an", 32'(an_o), 32'hF);
      if (n - 1 == 2) begin
        check("d0_an",  32'(an_o),  32'hE);
        check("d0_seg", 32'(seg_o), 32'h4C);
      end
      if (n - 1 == SLOT) check("inter_blank_an", 32'(an_o), 32'hF);
      if (frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = n - 1;
        else if ((n - 1) - fd_prev != FRAME) bad_gap++;
        fd_prev = n - 1;
      end
    end
    check("fd_count", 32'(fd_cnt),  32'd4);
    check("fd_first", 32'(fd_first), 32'(FRAME));
    check("fd_gap",   32'(bad_gap),  32'd0);

    // Two loads mid-frame: second waits until the cycle after frame_done.
    @(negedge clk);
    check("ready_x", 32'(load_ready), 32'h1);
    load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b0000;
    @(negedge clk);
    load_data = 16'h4321;
    check("ready_busy", 32'(load_ready), 32'h0);
    fd_i = -1; acc_i = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (frame_done) fd_i = i;
      if (load_ready) begin
        acc_i = i;
        break;
      end
    end
    check("fd_cycle",    32'(fd_i),  32'd19);
    check("ready_cycle", 32'(acc_i), 32'd20);
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    check("x_d0_an",     32'(an_o),       32'hE);
    check("x_d0_seg",    32'(seg_o),      32'h00);
    check("y_pending",   32'(load_ready), 32'h0);
    repeat (18) @(negedge clk);
    check("x_d3_an",     32'(an_o),  32'h7);
    check("x_d3_seg",    32'(seg_o), 32'h24);
    repeat (6) @(negedge clk);
    check("y_d0_seg",    32'(seg_o), 32'h4F);

    // enable dropped during digit 2: immediate blank, no frame_done, restart at digit 0.
    repeat (12) @(negedge clk);
    check("d2_an", 32'(an_o), 32'hB);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an",  32'(an_o),  32'hF);
    check("dis_seg", 32'(seg_o), 32'h7F);
    check("dis_dp",  32'(dp_o),  32'h1);
    fd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    check("dis_no_fd", 32'(fd_cnt), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("restart_blank", 32'(an_o), 32'hF);
    repeat (2) @(negedge clk);
    check("restart_d0_an",  32'(an_o),  32'hE);
    check("restart_d0_seg", 32'(seg_o), 32'h4F);

    // Reset mid-frame discards the pending word.
    load_valid = 1'b1; load_data = 16'h9999; load_dp = 4'hF;
    @(negedge clk);
    load_valid = 1'b0;
    check("pend_full", 32'(load_ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("async_ready", 32'(load_ready), 32'h1);
    check("async_an",    32'(an_o),       32'hF);
    check("async_seg",   32'(seg_o),      32'h7F);
    check("async_fd",    32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("discard_an",  32'(an_o),  32'hE);
    check("discard_seg", 32'(seg_o), 32'h01);
    check("discard_dp",  32'(dp_o),  32'h1);

    // Randomized run against the timeline model.
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        @(negedge clk);
        model_expect(ean, eseg, edp);
        check("random", 32'({an_o, seg_o, dp_o, frame_done, load_ready}),
              32'({ean, eseg, edp, m_fd, !m_pend_full}));
      end
      r_en  = ($urandom_range(99) != 0);
      r_lv  = ($urandom_range(2) == 0);
      r_ld  = 16'($urandom);
      case ($urandom_range(3))
        0: r_ld = r_ld & 16'h00FF;
        1: r_ld = r_ld & 16'h000F;
        2: r_ld = r_ld & 16'h0F0F;
        default: ;
      endcase
      r_ldp = 4'($urandom);
      enable = r_en; load_valid = r_lv; load_data = r_ld; load_dp = r_ldp;
      model_step(r_en, r_lv, r_ld, r_ldp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
